// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int unsigned WORD_OFFSET_BITS = 3;

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
  } dmem_req_t;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } dmem_rsp_t;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } slot_state_e;

endpackage

// File: rtl/dmem_rsp_queue.sv
// In-order response queue: one slot per outstanding request, each counting down its latency.
module dmem_rsp_queue
  import dmem_pkg::*;
#(
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned OUTSTANDING = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  dmem_rsp_t push_rsp,
  output logic      push_ready,
  output logic      pop_valid,
  input  logic      pop_ready,
  output dmem_rsp_t pop_rsp
);

  localparam int unsigned PtrW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CntW = $clog2(OUTSTANDING + 1);
  localparam int unsigned LatW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LatW-1:0] LatInit = LatW'(LATENCY - 1);

  slot_state_e     state_q [OUTSTANDING];
  logic [LatW-1:0] cnt_q   [OUTSTANDING];
  dmem_rsp_t       data_q  [OUTSTANDING];
  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] count_q;
  logic            pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // No pass-through: a full queue stays not-ready even if the head retires this cycle.
  assign push_ready = (count_q < CntW'(OUTSTANDING));
  assign pop_valid  = (state_q[head_q] == READY);
  assign pop_rsp    = pop_valid ? data_q[head_q] : '0;
  assign pop        = pop_valid && pop_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < OUTSTANDING; i++) begin
        state_q[i] <= FREE;
        cnt_q[i]   <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < OUTSTANDING; i++) begin
        if (state_q[i] == WAIT) begin
          if (cnt_q[i] == '0) state_q[i] <= READY;
          else                cnt_q[i]   <= cnt_q[i] - 1'b1;
        end
      end
      // Head is READY and tail is FREE whenever both fire, so they never alias.
      if (pop) begin
        state_q[head_q] <= FREE;
        head_q          <= ptr_inc(head_q);
      end
      if (push) begin
        state_q[tail_q] <= WAIT;
        cnt_q[tail_q]   <= LatInit;
        data_q[tail_q]  <= push_rsp;
        tail_q          <= ptr_inc(tail_q);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-enabled 64-bit RAM with fixed-latency in-order responses.
// Optional out-of-range error reporting is enabled by defining DMEM_RANGE_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IdxW  = $clog2(DEPTH_WORDS);
  localparam int unsigned WordW = 64 - WORD_OFFSET_BITS;

  dmem_req_t       req;
  dmem_rsp_t       slot_rsp, head_rsp;
  logic [63:0]     mem [DEPTH_WORDS];
  logic [IdxW-1:0] idx;
  logic            in_range, accept;
  logic            unused_addr;

  assign req    = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
  assign idx    = req.addr[WORD_OFFSET_BITS +: IdxW];
  assign accept = req_valid && req_ready && !rst;
  assign unused_addr = ^{req.addr[WORD_OFFSET_BITS-1:0], req.addr[63:WORD_OFFSET_BITS+IdxW]};

`ifdef DMEM_RANGE_CHECK_EN
  assign in_range = (req.addr[63:WORD_OFFSET_BITS] < WordW'(DEPTH_WORDS));
`else
  assign in_range = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (accept && req.we && in_range) begin
      for (int b = 0; b < 8; b++) begin
        if (req.be[b]) mem[idx][8*b +: 8] <= req.wdata[8*b +: 8];
      end
    end
  end

  // Read data is captured into the slot at the accept edge, so later writes cannot alter it.
  always_comb begin
    slot_rsp = '0;
    if (!in_range)    slot_rsp.err   = 1'b1;
    else if (!req.we) slot_rsp.rdata = mem[idx];
  end

  dmem_rsp_queue #(
    .LATENCY    (LATENCY),
    .OUTSTANDING(OUTSTANDING)
  ) u_rsp_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_rsp  (slot_rsp),
    .push_ready(req_ready),
    .pop_valid (rsp_valid),
    .pop_ready (rsp_ready),
    .pop_rsp   (head_rsp)
  );

  assign rsp_rdata = head_rsp.rdata;
  assign rsp_err   = head_rsp.err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: transaction-level reference model plus directed literal checks.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;
  localparam int unsigned OUTS  = 2;

`ifdef DMEM_RANGE_CHECK_EN
  localparam logic        EXP_RANGE_ERR = 1'b1;
  localparam logic [63:0] EXP_WORD0     = 64'h0123_4567_89AB_CDEF;
`else
  localparam logic        EXP_RANGE_ERR = 1'b0;
  localparam logic [63:0] EXP_WORD0     = 64'hFFFF_FFFF_FFFF_FFFF;
`endif

  logic        clk, rst;
  logic        req_valid, req_ready, req_we;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT),
    .OUTSTANDING(OUTS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_be   (req_be),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [64:0] got_q[$];
  logic [63:0] mem_m [DEPTH];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: advances on each edge using the specification's transaction rules.
  always @(posedge clk) begin
    bit          head_ok, room;
    exp_t        e;
    longint unsigned widx;
    int          idx;
    head_ok = (q.size() > 0) && (cyc >= q[0].due);
    room    = (q.size() < OUTS);
    if (rst) begin
      q.delete();
    end else begin
      if (head_ok && rsp_ready) void'(q.pop_front());
      if (req_valid && room) begin
        widx    = longint'(req_addr >> 3);
        idx     = int'(widx % DEPTH);
        e.rdata = '0;
        e.err   = 1'b0;
        e.due   = cyc + 1 + LAT;
`ifdef DMEM_RANGE_CHECK_EN
        if (widx >= DEPTH) e.err = 1'b1;
`endif
        if (!e.err) begin
          if (req_we) begin
            for (int b = 0; b < 8; b++)
              if (req_be[b]) mem_m[idx][8*b +: 8] = req_wdata[8*b +: 8];
          end else begin
            e.rdata = mem_m[idx];
          end
        end
        q.push_back(e);
      end
    end
    cyc++;
  end

  // Compare process: checks the DUT against the model every cycle away from the edge.
  always @(negedge clk) begin
    bit exp_valid;
    if (!rst) begin
      exp_valid = (q.size() > 0) && (cyc >= q[0].due);
      check64("req_ready", {63'd0, req_ready}, {63'd0, q.size() < OUTS});
      check64("rsp_valid", {63'd0, rsp_valid}, {63'd0, exp_valid});
      if (exp_valid && rsp_valid) begin
        check64("rsp_rdata", rsp_rdata, q[0].rdata);
        check64("rsp_err", {63'd0, rsp_err}, {63'd0, q[0].err});
        if (rsp_ready) got_q.push_back({rsp_rdata, rsp_err});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [7:0] be);
    logic acc;
    int   n;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    n = 0;
    do begin
      acc = req_ready;
      tick();
      n++;
    end while (!acc && n < 50);
    if (!acc) check64("accept_timeout", 64'd0, 64'd1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    if (q.size() != 0) check64("drain_timeout", 64'(q.size()), 64'd0);
    tick();
  endtask

  initial begin
    int n, base;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check64("reset_req_ready", {63'd0, req_ready}, 64'd1);
    check64("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check64("reset_rsp_rdata", rsp_rdata, 64'd0);
    check64("reset_rsp_err", {63'd0, rsp_err}, 64'd0);

    // Basic write then read with latency measurement.
    issue(1'b1, 64'h10, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
    drain();
    issue(1'b0, 64'h10, 64'h0, 8'h00);
    n = 0;
    while (!rsp_valid && n < 10) begin
      tick();
      n++;
    end
    check64("read_latency", 64'(n), 64'(LAT));
    check64("basic_rdata", rsp_rdata, 64'hDEAD_BEEF_CAFE_F00D);
    check64("basic_err", {63'd0, rsp_err}, 64'd0);
    drain();

    // Byte-enable merge.
    base = got_q.size();
    issue(1'b1, 64'h20, 64'h1122_3344_5566_7788, 8'hFF);
    issue(1'b1, 64'h20, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
    issue(1'b0, 64'h20, 64'h0, 8'h00);
    drain();
    check64("merge_count", 64'(got_q.size() - base), 64'd3);
    check64("merge_wr_rsp", got_q[base+1][64:1], 64'd0);
    check64("merge_rdata", got_q[base+2][64:1], 64'h1122_3344_AAAA_AAAA);

    // Backpressure and full queue.
    base = got_q.size();
    rsp_ready = 1'b0;
    issue(1'b0, 64'h10, 64'h0, 8'h00);
    issue(1'b0, 64'h20, 64'h0, 8'h00);
    check64("full_req_ready", {63'd0, req_ready}, 64'd0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h10;
    tick();
    for (int i = 0; i < 5; i++) begin
      check64("stall_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      check64("stall_rsp_rdata", rsp_rdata, 64'hDEAD_BEEF_CAFE_F00D);
      check64("stall_req_ready", {63'd0, req_ready}, 64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    issue(1'b0, 64'h10, 64'h0, 8'h00);
    drain();
    check64("bp_count", 64'(got_q.size() - base), 64'd3);
    check64("bp_order0", got_q[base][64:1], 64'hDEAD_BEEF_CAFE_F00D);
    check64("bp_order1", got_q[base+1][64:1], 64'h1122_3344_AAAA_AAAA);
    check64("bp_order2", got_q[base+2][64:1], 64'hDEAD_BEEF_CAFE_F00D);
    check64("bp_req_ready", {63'd0, req_ready}, 64'd1);

    // Read-after-write on consecutive cycles; zero byte-enable write leaves data intact.
    base = got_q.size();
    issue(1'b1, 64'h40, 64'h5, 8'hFF);
    issue(1'b0, 64'h40, 64'h0, 8'h00);
    issue(1'b1, 64'h40, 64'hFFFF_0000_FFFF_0000, 8'h00);
    issue(1'b0, 64'h44, 64'h0, 8'h00);
    drain();
    check64("raw_rdata", got_q[base+1][64:1], 64'h5);
    check64("be0_err", {63'd0, got_q[base+2][0]}, 64'd0);
    check64("be0_rdata", got_q[base+3][64:1], 64'h5);

    // Address beyond the RAM.
    base = got_q.size();
    issue(1'b1, 64'h0, 64'h0123_4567_89AB_CDEF, 8'hFF);
    issue(1'b1, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    issue(1'b0, 64'h0, 64'h0, 8'h00);
    drain();
    check64("range_wr_err", {63'd0, got_q[base+1][0]}, {63'd0, EXP_RANGE_ERR});
    check64("range_wr_rdata", got_q[base+1][64:1], 64'd0);
    check64("range_word0", got_q[base+2][64:1], EXP_WORD0);

    // Reset with two reads in flight.
    rsp_ready = 1'b0;
    issue(1'b0, 64'h10, 64'h0, 8'h00);
    issue(1'b0, 64'h20, 64'h0, 8'h00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check64("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check64("rst_req_ready", {63'd0, req_ready}, 64'd1);
    base = got_q.size();
    rsp_ready = 1'b1;
    repeat (6) tick();
    check64("rst_no_rsp", 64'(got_q.size() - base), 64'd0);
    check64("rst_rsp_valid_late", {63'd0, rsp_valid}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
